// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver: parity modes, FSM states,
// the tick divider calculation and small bit-level helpers.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 32'd0;
  localparam int unsigned PARITY_ODD  = 32'd1;
  localparam int unsigned PARITY_EVEN = 32'd2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_e;

  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    return clk_hz / (baud * os);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // ones_odd is the XOR over data and parity bit
  function automatic logic parity_bad(input int unsigned mode, input logic ones_odd);
    logic bad;
    case (mode)
      PARITY_ODD:  bad = ~ones_odd;
      PARITY_EVEN: bad = ones_odd;
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; full/empty come from pointers carrying an extra wrap bit.
// A write while full is accepted only when a read frees a slot in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_wr_s;
  logic             do_rd_s;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // Next-state for pointers and storage
  always_comb begin
    do_rd_s  = rd_en & ~empty;
    do_wr_s  = wr_en & (~full | do_rd_s);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr_s) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_rd_s) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // FIFO state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with majority-vote bit sampling, sticky error flags
// and a small receive FIFO.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_HZ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 empty,
  output logic                 full,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  input  logic                 err_clr
);

  localparam int unsigned DIV   = calc_div(CLOCK_HZ, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
  localparam int unsigned BC_W  = 4;

  rx_state_e            state_q, state_d;
  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_sync_q, rx_sync_d;
  logic                 rx_prev_q, rx_prev_d;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
  logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 frame_bad_q, frame_bad_d;
  logic                 push_q, push_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q, overrun_d;

  logic tick_s, bit_end_s, samp_a_s, samp_b_s, decide_s, maj_s;
  logic fe_evt_s, pe_evt_s, ov_evt_s, stop_bad_s;
  logic fifo_full_s;

  // Ticks are numbered 1..OVERSAMPLE within a bit; os_cnt_q holds (tick number - 1).
  assign tick_s    = (div_cnt_q == DIV_W'(DIV - 1));
  assign bit_end_s = tick_s && (os_cnt_q == OS_W'(OVERSAMPLE - 1));
  assign samp_a_s  = tick_s && (os_cnt_q == OS_W'(OVERSAMPLE/2 - 2));
  assign samp_b_s  = tick_s && (os_cnt_q == OS_W'(OVERSAMPLE/2 - 1));
  assign decide_s  = tick_s && (os_cnt_q == OS_W'(OVERSAMPLE/2));
  assign maj_s     = maj3(samp_q[1], samp_q[0], rx_sync_q);
  assign ov_evt_s  = push_q & fifo_full_s & ~rd_en;

  // Receiver FSM, timing counters and sticky flag next-state
  always_comb begin
    rx_meta_d   = rx;
    rx_sync_d   = rx_meta_q;
    rx_prev_d   = rx_sync_q;
    state_d     = state_q;
    div_cnt_d   = tick_s ? '0 : div_cnt_q + DIV_W'(1);
    os_cnt_d    = os_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    samp_d      = samp_q;
    shift_d     = shift_q;
    par_d       = par_q;
    frame_bad_d = frame_bad_q;
    push_d      = 1'b0;
    fe_evt_s    = 1'b0;
    pe_evt_s    = 1'b0;
    stop_bad_s  = 1'b0;

    if (bit_end_s) begin
      os_cnt_d = '0;
    end else if (tick_s) begin
      os_cnt_d = os_cnt_q + OS_W'(1);
    end else begin
      os_cnt_d = os_cnt_q;
    end

    if (samp_a_s || samp_b_s) begin
      samp_d = {samp_q[0], rx_sync_q};
    end else begin
      samp_d = samp_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          state_d     = ST_START;
          div_cnt_d   = '0;
          os_cnt_d    = '0;
          frame_bad_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      // A high line at mid start bit is a glitch; otherwise ride out the start bit
      ST_START: begin
        if (samp_b_s && rx_sync_q) begin
          state_d = ST_IDLE;
        end else if (bit_end_s) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (decide_s) begin
          shift_d   = {maj_s, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BC_W'(1);
        end else if (bit_end_s && (bit_cnt_q == BC_W'(DATA_BITS))) begin
          bit_cnt_d = '0;
          state_d   = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (decide_s) begin
          par_d = maj_s;
        end else if (bit_end_s) begin
          state_d   = ST_STOP;
          bit_cnt_d = '0;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (decide_s) begin
          stop_bad_s = frame_bad_q | ~maj_s;
          if (bit_cnt_q == BC_W'(STOP_BITS - 1)) begin
            fe_evt_s  = stop_bad_s;
            pe_evt_s  = parity_bad(PARITY, ^{shift_q, par_q});
            push_d    = ~fe_evt_s & ~pe_evt_s;
            bit_cnt_d = '0;
            state_d   = stop_bad_s ? ST_WAIT_HIGH : ST_IDLE;
          end else begin
            frame_bad_d = stop_bad_s;
            bit_cnt_d   = bit_cnt_q + BC_W'(1);
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_sync_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_HIGH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    frame_err_d  = (frame_err_q  & ~err_clr) | fe_evt_s;
    parity_err_d = (parity_err_q & ~err_clr) | pe_evt_s;
    overrun_d    = (overrun_q    & ~err_clr) | ov_evt_s;
  end

  // Receiver state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      div_cnt_q    <= '0;
      os_cnt_q     <= '0;
      bit_cnt_q    <= '0;
      samp_q       <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      frame_bad_q  <= 1'b0;
      push_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_meta_q    <= rx_meta_d;
      rx_sync_q    <= rx_sync_d;
      rx_prev_q    <= rx_prev_d;
      div_cnt_q    <= div_cnt_d;
      os_cnt_q     <= os_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      samp_q       <= samp_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      frame_bad_q  <= frame_bad_d;
      push_q       <= push_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push_q),
    .wr_data (shift_q),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (fifo_full_s)
  );

  assign full       = fifo_full_s;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter CLOCK_HZ, 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, 115200, serial bit rate.
REQ-003 Parameter OVERSAMPLE, 16, sample ticks per bit; even, at least 8.
REQ-004 Parameter DATA_BITS, 8, data bits per frame; legal range 5 to 8.
REQ-005 Parameter PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
REQ-006 Parameter STOP_BITS, 1, stop bits checked; legal values 1 or 2.
REQ-007 Parameter FIFO_DEPTH, 4, receive FIFO entries; power of two.
REQ-008 Port clk, input, 1, single system clock; all logic on its rising edge.
REQ-009 Port rst_n, input, 1, asynchronous active-low reset.
REQ-010 Port rx, input, 1, asynchronous serial line; idle high.
REQ-011 Port rd_en, input, 1, pop the FIFO head this cycle.
REQ-012 Port rd_data, output, DATA_BITS, FIFO head; show-ahead.
REQ-013 Port empty, output, 1, FIFO holds no entries.
REQ-014 Port full, output, 1, FIFO holds FIFO_DEPTH entries.
REQ-015 Port frame_err, output, 1, sticky: a stop bit sampled low.
REQ-016 Port parity_err, output, 1, sticky: parity mismatch.
REQ-017 Port overrun, output, 1, sticky: a completed byte was dropped because the FIFO was full.
REQ-018 Port err_clr, input, 1, clears all three sticky flags.

Function
REQ-019 rx shall pass through a two-flop synchronizer before any use.
REQ-020 The tick divider shall be DIV = floor(CLOCK_HZ/(BAUD_RATE*OVERSAMPLE)), giving one tick every DIV clocks. With default parameters DIV is 27.
REQ-021 The state machine shall have the states IDLE, START, DATA, PARITY, STOP and WAIT_HIGH.
REQ-022 IDLE shall move to START on a synchronized falling edge of rx, and the tick counter shall restart at that edge.
REQ-023 START shall re-sample rx at tick OVERSAMPLE/2. If rx is low, go to DATA. If rx is high, treat it as a glitch and return to IDLE with no flags set.
REQ-024 Each data, parity and stop bit shall be the 2-of-3 majority of the samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. Data bits are received LSB first.
REQ-025 PARITY shall be entered only when PARITY is not 0. Odd parity requires an odd count of ones over the data and parity bits. Even parity requires an even count.
REQ-026 STOP shall check STOP_BITS consecutive bits. After the final stop-bit majority decision, the FSM shall return to IDLE immediately, without waiting for the end of the bit.
REQ-027 A low stop bit shall set frame_err, discard the byte and move to WAIT_HIGH. WAIT_HIGH shall return to IDLE once rx is high (break handling).
REQ-028 A parity mismatch shall set parity_err and discard the byte. A frame with both a parity mismatch and a low stop bit shall set both flags.
REQ-029 A good byte shall be pushed into the FIFO one clk after the final stop-bit decision, and empty shall deassert in that same cycle.
REQ-030 A push while full shall drop the byte and set overrun. The FIFO contents shall be unchanged.
REQ-031 A push and a pop in the same cycle while full shall both succeed and shall not set overrun.
REQ-032 rd_en while empty shall be ignored: no pointer change and no flag.
REQ-033 If err_clr and a new error occur in the same cycle, the flag shall end that cycle set.
REQ-034 FIFO pointers shall wrap modulo FIFO_DEPTH. full and empty shall be derived from an extra pointer wrap bit.

Reset
REQ-035 Asserting rst_n low shall asynchronously force the following values, including in the middle of a frame:
- FSM state IDLE, all counters 0, synchronizer flops 1;
- FIFO empty: empty=1, full=0;
- rd_data=0;
- frame_err, parity_err and overrun all 0.
REQ-036 After rst_n is released, only a new falling edge on rx shall start a frame.

Structure
REQ-037 Package uart_pkg shall hold:
- the parity-mode constants PARITY_NONE, PARITY_ODD and PARITY_EVEN;
- the FSM state typedef;
- the function that computes DIV.
REQ-038 The FIFO shall be a separate sub-module, sync_fifo, parametrised by width and depth.

Verification
REQ-039 Defaults, rx sends 0x55 as 8N1 at 434 clocks per bit. Required: empty falls, rd_data=0x55, all error flags 0.
REQ-040 Defaults, send 0xA3 with its stop bit low. Required: frame_err=1, empty stays 1. After rx returns high, a following 0x3C is received correctly.
REQ-041 Defaults, send 0x01 to 0x05 back to back with no reads. Required: full=1 after the 4th byte, and overrun=1 after the 5th. Four pops return 0x01, 0x02, 0x03, 0x04, then empty=1.
REQ-042 Defaults, pulse rx low for 100 ns while idle. Required: no byte pushed, no flags set.
REQ-043 PARITY=2, send 0x07 with parity bit 0. Required: parity_err=1, no push. err_clr then clears it to 0.
REQ-044 Assert rst_n low during data bit 4 of a frame. Required: all outputs take their reset values. The next full frame 0x96 is received correctly.
